// File: rtl/config_writer.sv
// config_writer: persists the video configuration byte into SRAM.
//
// Captures the boot VGA/scanline settings when pwon_reset falls, applies toggle
// pulses to a shadow copy and writes the shadow byte to the config location over
// the byte-addressed SRAM port after an arbiter grant.
//
// Optional feature macro: CONFIG_WRITER_VERIFY_EN builds the read-back
// verify/retry path and the sticky error flag.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   pwon_reset              high while the config reader owns SRAM
//   vga_on_in               boot value of the VGA mode bit
//   scanlines_off_in        boot value of the scanline-disable bit
//   toggle_vga              one-cycle pulse inverting the VGA mode
//   toggle_scanlines        one-cycle pulse inverting the scanline setting
//   bus_req / bus_gnt       SRAM port request / arbiter grant
//   sram_addr               21-bit byte address (config location while requesting)
//   sram_we_n, sram_oe_n    active-low write strobe / output enable
//   sram_data_out           byte written
//   sram_data_in            byte read back (verify build only)
//   vga_on, scanlines_off   live shadow settings
//   busy                    FSM not idle
//   error                   sticky verify failure
module config_writer #(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned WE_CYCLES    = 2,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwon_reset,
  input  logic        vga_on_in,
  input  logic        scanlines_off_in,
  input  logic        toggle_vga,
  input  logic        toggle_scanlines,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [20:0] sram_addr,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic [7:0]  sram_data_out,
  input  logic [7:0]  sram_data_in,
  output logic        vga_on,
  output logic        scanlines_off,
  output logic        busy,
  output logic        error
);

  localparam logic [20:0] CfgAddr = 21'h008FD5;

  typedef enum logic [2:0] {
    StIdle, StReq, StSetup, StWrite, StRecover, StVerify, StCheck
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pwon_q, captured_q, captured_d;
  logic        vga_q, vga_d, soff_q, soff_d;
  logic        dirty_q, dirty_d;
  logic [7:0]  wbyte_q, wbyte_d;
  logic        bus_req_q, we_n_q, oe_n_d, oe_n_q;
  logic [20:0] addr_q;
  logic [7:0]  data_q;
  logic        retry_ok, verify_match;
  logic        error_set, retry_inc, retry_clr, rd_load;

`ifdef CONFIG_WRITER_VERIFY_EN
  logic [2:0] retry_q;
  logic [7:0] rd_q;
  logic       error_q;

  assign retry_ok     = retry_q < 3'(MAX_RETRIES);
  assign verify_match = rd_q == wbyte_q;
`else
  logic [7:0] unused_data_in;
  logic [2:0] unused_max_retries;

  assign unused_data_in     = sram_data_in;
  assign unused_max_retries = 3'(MAX_RETRIES);
  assign retry_ok           = 1'b0;
  assign verify_match       = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    captured_d = captured_q;
    vga_d      = vga_q;
    soff_d     = soff_q;
    dirty_d    = dirty_q;
    wbyte_d    = wbyte_q;
    error_set  = 1'b0;
    retry_inc  = 1'b0;
    retry_clr  = 1'b0;
    rd_load    = 1'b0;

    // Aborting on grant loss takes priority over every in-flight transition.
    if ((state_q != StIdle) && (state_q != StReq) && !bus_gnt) begin
      state_d = StReq;
      cnt_d   = '0;
      dirty_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (dirty_q) begin
            wbyte_d = {6'b0, ~soff_q, vga_q};
            dirty_d = 1'b0;
            state_d = StReq;
          end
        end
        StReq: begin
          if (bus_gnt) begin
            state_d = StSetup;
            cnt_d   = '0;
          end
        end
        StSetup: begin
          if (cnt_q == 4'(SETUP_CYCLES - 1)) begin
            state_d = StWrite;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        StWrite: begin
          if (cnt_q == 4'(WE_CYCLES - 1)) begin
            state_d = StRecover;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        StRecover: begin
`ifdef CONFIG_WRITER_VERIFY_EN
          state_d = StVerify;
`else
          state_d = StIdle;
`endif
          cnt_d = '0;
        end
        StVerify: begin
          // Read data is captured on the edge that ends the second OE cycle.
          if (cnt_q == 4'd1) begin
            rd_load = 1'b1;
            state_d = StCheck;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        StCheck: begin
          if (verify_match) begin
            retry_clr = 1'b1;
            state_d   = StIdle;
          end else if (retry_ok) begin
            retry_inc = 1'b1;
            state_d   = StSetup;
            cnt_d     = '0;
          end else begin
            error_set = 1'b1;
            retry_clr = 1'b1;
            state_d   = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Shadow: capture on the sampled fall of pwon_reset, then toggles.
    if (pwon_q && !pwon_reset) begin
      vga_d      = vga_on_in;
      soff_d     = scanlines_off_in;
      captured_d = 1'b1;
    end else if (captured_q && !pwon_reset && (toggle_vga || toggle_scanlines)) begin
      vga_d   = vga_q ^ toggle_vga;
      soff_d  = soff_q ^ toggle_scanlines;
      // Re-arms even in the cycle IDLE latches, so late toggles get their own write.
      dirty_d = 1'b1;
    end

    oe_n_d = (state_d != StVerify);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pwon_q     <= 1'b0;
      captured_q <= 1'b0;
      vga_q      <= 1'b0;
      soff_q     <= 1'b1;
      dirty_q    <= 1'b0;
      wbyte_q    <= '0;
      bus_req_q  <= 1'b0;
      addr_q     <= '0;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pwon_q     <= pwon_reset;
      captured_q <= captured_d;
      vga_q      <= vga_d;
      soff_q     <= soff_d;
      dirty_q    <= dirty_d;
      wbyte_q    <= wbyte_d;
      bus_req_q  <= (state_d != StIdle);
      addr_q     <= (state_d != StIdle) ? CfgAddr : '0;
      we_n_q     <= (state_d != StWrite);
      oe_n_q     <= oe_n_d;
      data_q     <= ((state_d == StSetup) || (state_d == StWrite) || (state_d == StRecover))
                    ? wbyte_d : '0;
    end
  end

`ifdef CONFIG_WRITER_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= '0;
      rd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      if (rd_load)        rd_q    <= sram_data_in;
      if (retry_clr)      retry_q <= '0;
      else if (retry_inc) retry_q <= retry_q + 3'd1;
      if (error_set)      error_q <= 1'b1;
    end
  end

  assign sram_oe_n = oe_n_q;
  assign error     = error_q;
`else
  logic unused_oe_n;
  logic unused_verify;

  assign unused_oe_n   = oe_n_q;
  assign unused_verify = ^{error_set, retry_inc, retry_clr, rd_load, retry_ok, verify_match};
  assign sram_oe_n     = 1'b1;
  assign error         = 1'b0;
`endif

  assign bus_req       = bus_req_q;
  assign busy          = bus_req_q;
  assign sram_addr     = addr_q;
  // Grant loss releases the strobe combinationally, ahead of the registered abort.
  assign sram_we_n     = we_n_q | ~bus_gnt;
  assign sram_data_out = data_q;
  assign vga_on        = vga_q;
  assign scanlines_off = soff_q;

endmodule

// File: doc/config_writer.md
# config_writer

Persists the video configuration byte into SRAM so the power-on config reader picks it up on the next boot. Sits directly upstream of the SRAM power-on mux: it captures the live VGA/scanline settings once power-on reset ends, applies user toggle pulses to a shadow copy, and writes the changed byte back to the config location. The write uses the mux's 21-bit byte-addressed SRAM interface after an arbiter grant.

## Interface

Parameters:

- `SETUP_CYCLES`, default 1: cycles that address and data are held before `sram_we_n` falls (1..15).
- `WE_CYCLES`, default 2: cycles that `sram_we_n` is held low (1..15).
- `MAX_RETRIES`, default 3: verify-failure retries before `error` is set (0..7).

Ports:

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pwon_reset` in 1: high while the config reader owns SRAM.
- `vga_on_in` in 1: boot value of the VGA mode bit.
- `scanlines_off_in` in 1: boot value of the scanline-disable bit.
- `toggle_vga` in 1: one-cycle pulse that inverts the VGA mode.
- `toggle_scanlines` in 1: one-cycle pulse that inverts the scanline setting.
- `bus_req` out 1: request for the SRAM port.
- `bus_gnt` in 1: grant from the arbiter.
- `sram_addr` out 21: bit 20 selects the upper byte. Always 21'h008FD5 while `bus_req` is high, else 0.
- `sram_we_n` out 1: write strobe, active low.
- `sram_oe_n` out 1: output enable, active low.
- `sram_data_out` out 8: byte to write.
- `sram_data_in` in 8: byte read back.
- `vga_on` out 1: live shadow VGA mode bit.
- `scanlines_off` out 1: live shadow scanline-disable bit.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `error` out 1: sticky verify failure. Cleared only by `rst_n`.

## Operation

Shadow byte:

- Bit 0 = `vga_on`.
- Bit 1 = ~`scanlines_off`.
- Bits 7:2 = 0.

Capture and toggles:

- On the falling edge of `pwon_reset` (high, then low, sampled), the shadow loads from `vga_on_in` and `scanlines_off_in`. Cycle of the low sample +1.
- Toggles are ignored until capture has happened, and ignored while `pwon_reset` is high.
- A toggle updates the shadow on the next edge. Both toggles in the same cycle invert both bits.
- Any toggle sets `dirty`.

FSM states: IDLE, REQ, SETUP, WRITE, RECOVER, VERIFY, CHECK.

- **IDLE:** if `dirty`, latch the shadow into `wbyte`, clear `dirty`, go to REQ.
- **REQ:** assert `bus_req`. When `bus_gnt` is high, go to SETUP.
- **SETUP:** drive address and `wbyte`, with `sram_we_n`=1 and `sram_oe_n`=1, for `SETUP_CYCLES`. Then go to WRITE.
- **WRITE:** `sram_we_n`=0 for `WE_CYCLES`. Then go to RECOVER.
- **RECOVER:** one cycle with `sram_we_n`=1 and data still driven. Then go to VERIFY if the macro is defined, else IDLE.
- **VERIFY:** `sram_oe_n`=0 for 2 cycles. Sample `sram_data_in` at the end of the second cycle, then go to CHECK.
- **CHECK:**
  - Match: reset the retry counter and go to IDLE.
  - Mismatch with retries remaining: increment the counter and go to SETUP.
  - Mismatch with retries exhausted: set `error`, go to IDLE, and drop the pending write.

Bus ownership and coalescing:

- `bus_req` stays high from REQ through the exit to IDLE, and drops on the IDLE entry edge.
- A toggle while busy sets `dirty` again. The next write happens after returning to IDLE, so any number of toggles coalesce into one write.

Grant loss and reset:

- If `bus_gnt` drops in any state after REQ, the FSM aborts to REQ: `sram_we_n`=1 immediately (combinational), `dirty` is set again, and the retry counter is unchanged.
- `rst_n` low mid-write immediately forces all outputs to their reset values. No partial strobe continues.

## Timing

Reset values:

- `bus_req`=0, `sram_addr`=0, `sram_we_n`=1, `sram_oe_n`=1, `sram_data_out`=0.
- `vga_on`=0, `scanlines_off`=1, `busy`=0, `error`=0.
- FSM in IDLE, `dirty`=0, capture flag=0.

Latency:

- All outputs are registered except the grant-loss override of `sram_we_n`.
- Toggle to `busy` high: 2 cycles (shadow update, then IDLE→REQ).
- With `bus_gnt` already high, from REQ entry to `sram_we_n` falling: 1 + `SETUP_CYCLES` cycles.
- Full write without verify: 1 + `SETUP_CYCLES` + `WE_CYCLES` + 1 cycles of `bus_req`.
- Verify adds 3 cycles.

Sequencing:

- `sram_data_out` is stable from SETUP entry to RECOVER exit.
- `sram_we_n` and `sram_oe_n` are never low in the same cycle.

## Configuration

- `CONFIG_WRITER_VERIFY_EN` defined: the VERIFY and CHECK states, the retry counter and `error` are built. RECOVER goes to VERIFY.
- Not defined: RECOVER goes to IDLE, `sram_oe_n` is tied to 1, `error` is tied to 0, and `sram_data_in` is unused.

## Test plan

- Capture: `vga_on_in`=1, `scanlines_off_in`=0, release `pwon_reset` → `vga_on`=1, `scanlines_off`=0. No write occurs and `busy` stays 0.
- Single toggle: `toggle_vga` pulse with `bus_gnt`=1 → the write sequence puts `sram_data_out`=8'h02 at address 21'h008FD5. `sram_we_n` is low for exactly 2 cycles (default parameters).
- Coalescing: 3 `toggle_scanlines` pulses during WRITE → exactly one further write, with bit 1 inverted relative to the previous write.
- Grant loss: deassert `bus_gnt` in the 1st WRITE cycle → `sram_we_n`=1 in the same cycle and the FSM returns to REQ. On re-grant, a full write of the same byte follows.
- Verify retry (macro on): `sram_data_in` forced to 8'hFF → 4 write attempts (1 + `MAX_RETRIES`), then `error`=1, `busy`=0 and `bus_req`=0.
- Reset mid-write: drive `rst_n` low during WRITE → `sram_we_n`=1, `bus_req`=0, `vga_on`=0 and `scanlines_off`=1 asynchronously. Toggles are ignored until the next `pwon_reset` fall.
